alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Execution-stage consumer of the 3-bit ALU control code produced by the ALU control decoder. Executes add, sub, xor, and, sll, srai and mul on two operands from the ID/EX register.
- Single-cycle ops return a registered result.
- mul runs an iterative shift-add over WIDTH cycles and freezes the pipeline through stall_o.
- Result feeds the EX/MEM register and forwarding paths.

Parameters:
WIDTH, 32, operand/result width; also the mul iteration count
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
valid_i  input  1  operation presented this cycle
ALUCtrl_i  input  3  000 add, 001 sub, 010 mul, 011 xor, 100 sll, 101 srai, 110 and, 111 reserved
data1_i  input  WIDTH  operand A
data2_i  input  WIDTH  operand B; shift amount is data2_i[SHW-1:0]
flush_i  input  1  abort in-flight/presented op (mispredict flush)
ready_o  output  1  unit can accept an op this cycle
stall_o  output  1  pipeline freeze request (combinational)
valid_o  output  1  data_o is a new result this cycle (one-cycle pulse)
data_o  output  WIDTH  result, held between results
zero_o  output  1  (data_o == 0), combinational from data_o

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, valid_o=0, data_o=0, zero_o=1.
  - Internal multiplicand, multiplier, accumulator and counter cleared.
  - Reset mid-mul discards the op.
- States:
  - IDLE: ready_o=1.
  - MUL: ready_o=0.
- Acceptance: at a rising edge with state=IDLE, valid_i=1, flush_i=0.
- Single-cycle ops (any code except 010):
  - At the acceptance edge: data_o <= result, valid_o <= 1. Latency 1 cycle.
  - add/sub wrap modulo 2^WIDTH.
  - sll/srai use only data2_i[SHW-1:0]; srai replicates data1_i[WIDTH-1].
  - 111 yields data_o=0 with valid_o=1.
- mul (010):
  - At the acceptance edge: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; state->MUL; valid_o stays 0.
  - Each MUL edge, in this order:
    - if mplier[0] then acc += mcand
    - mcand <<= 1
    - mplier >>= 1
    - cnt++
  - Exactly WIDTH iterations with no early termination. On the edge where cnt reaches WIDTH: data_o <= next acc (low WIDTH bits), valid_o <= 1, state->IDLE.
  - valid_o is high in the cycle WIDTH+1 cycles after the acceptance cycle.
  - Low-word result is identical for signed and unsigned operands.
- stall_o = (state==MUL & ~flush_i) | (state==IDLE & valid_i & ALUCtrl_i==010 & ~flush_i).
  - Asserted in the issue cycle and every MUL cycle except the completion cycle.
  - In the completion cycle stall_o=0, so EX/MEM captures data_o/valid_o when they are presented.
- valid_o is a single-cycle pulse; it deasserts at the next edge unless a new op is accepted on that edge.
- valid_i while state=MUL: ignored, not queued. The pipeline is stalled, so the same op is re-presented.
- flush_i:
  - In MUL: state->IDLE at the next edge; no valid_o; data_o unchanged.
  - In IDLE: inhibits acceptance; valid_o <= 0.
  - Simultaneous with the completion edge: flush wins, no valid_o, data_o unchanged.
- Back-to-back issue: a new op may be accepted on the edge immediately after the mul completion edge, because ready_o=1 in the valid_o cycle.

Test Plan:
- Reset release, then valid_i with sub, data1=5, data2=7 -> next cycle valid_o=1, data_o=0xFFFFFFFE, zero_o=0; following cycle valid_o=0, data_o held.
- srai data1=0x80000000, data2=0x00000024 (shamt 4) -> data_o=0xF8000000. sll data1=1, data2=31 -> 0x80000000.
- mul data1=7, data2=0xFFFFFFFD:
  - stall_o=1 in the issue cycle, ready_o=0 for 32 cycles.
  - valid_o=1 exactly 33 cycles after issue, with data_o=0xFFFFFFEB.
  - stall_o=0 in that cycle.
- mul 0x00010000 x 0x00010000 -> data_o=0, zero_o=1.
  - Drive valid_i with add during busy -> ignored.
  - Re-present add 1+2 in the valid_o cycle -> accepted, data_o=3 next cycle.
- flush_i pulsed on the 10th MUL cycle -> state IDLE next cycle, ready_o=1, no valid_o, data_o keeps its prior value.
- rst_i pulsed low asynchronously mid-mul -> valid_o=0, data_o=0, ready_o=1 immediately; no stale result after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execution-stage ALU. It consumes the 3-bit ALU control code and runs one of
// seven operations on the two ID/EX operands:
//   - add, sub, xor, and, sll and srai finish in one cycle and return a
//     registered result.
//   - mul is an iterative shift-add over WIDTH cycles. While it runs, the unit
//     asks the pipeline to freeze through stall_o.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous reset, active-low
//   valid_i    : an operation is presented this cycle
//   ALUCtrl_i  : 000 add, 001 sub, 010 mul, 011 xor, 100 sll, 101 srai,
//                110 and, 111 reserved (result 0)
//   data1_i    : operand A
//   data2_i    : operand B; shifts use only data2_i[SHW-1:0]
//   flush_i    : abort the presented or in-flight operation
//   ready_o    : unit can accept an operation this cycle
//   stall_o    : pipeline freeze request (combinational)
//   valid_o    : data_o carries a new result this cycle (one-cycle pulse)
//   data_o     : result, held between results
//   zero_o     : data_o == 0 (combinational from data_o)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);
  // The counter is one bit wider than SHW so that it can hold the value WIDTH.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] acc_step;

  // Result of every single-cycle operation. The reserved code, and mul (which
  // never reaches this path), return zero.
  function automatic logic [WIDTH-1:0] alu_single(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_SLL:  return a << sh;
      OP_SRA:  return WIDTH'($signed(a) >>> sh);
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // One shift-add step. The multiplicand is added before it is shifted.
  always_comb begin
    if (mplier_q[0]) begin
      acc_step = acc_q + mcand_q;
    end else begin
      acc_step = acc_q;
    end
  end

  // Next-state logic for the state machine, the multiplier datapath and the
  // result registers.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CW{1'b0}};
            state_d  = MUL;
          end else begin
            data_d  = alu_single(ALUCtrl_i, data1_i, data2_i);
            valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        // A flush abandons the multiply, even on its final iteration.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            data_d  = acc_step;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MUL;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      data_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // stall_o is high in the mul issue cycle and in every busy cycle. It drops in
  // the cycle that presents the mul result, so EX/MEM can capture that result.
  always_comb begin
    ready_o = (state_q == IDLE);
    stall_o = ((state_q == MUL) && !flush_i) ||
              ((state_q == IDLE) && valid_i && (ALUCtrl_i == OP_MUL) && !flush_i);
    valid_o = valid_q;
    data_o  = data_q;
    zero_o  = (data_q == {WIDTH{1'b0}});
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then check valid_o and compare any result against the scoreboard.
  task automatic step_chk(input logic exp_valid, input string tag);
    logic [31:0] e;
    @(posedge clk_i);
    #1;
    chk({tag, ":valid_o"}, {31'd0, valid_o}, {31'd0, exp_valid});
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s:unexpected_result got data_o=%h with empty scoreboard", tag, data_o);
      end else begin
        e = sb_q.pop_front();
        chk({tag, ":data_o"}, data_o, e);
        chk({tag, ":zero_o"}, {31'd0, zero_o}, {31'd0, (e == 32'd0)});
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i   = v;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  // Present a mul in the issue cycle, check that stall_o rises, and move into busy cycle 1.
  task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input bit push, input string tag);
    drive(1'b1, 3'b010, a, b);
    if (push) sb_q.push_back(a * b);
    #1;
    chk({tag, ":issue_stall"}, {31'd0, stall_o}, 32'd1);
    step_chk(1'b0, tag);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  // Run all 32 busy cycles. Optionally present an add mid-way, which must be ignored.
  task automatic run_mul(input bit inject, input string tag);
    for (int k = 1; k <= 32; k++) begin
      chk({tag, ":busy_ready"}, {31'd0, ready_o}, 32'd0);
      chk({tag, ":busy_stall"}, {31'd0, stall_o}, 32'd1);
      if (inject && k == 3) drive(1'b1, 3'b000, 32'd5, 32'd5);
      if (inject && k == 6) drive(1'b0, 3'b000, 32'd0, 32'd0);
      step_chk(k == 32, tag);
    end
  endtask

  initial begin
    vecs[0] = '{3'b001, 32'd5,          32'd7,          32'hFFFF_FFFE};
    vecs[1] = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[2] = '{3'b011, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00};
    vecs[3] = '{3'b110, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0};
    vecs[4] = '{3'b100, 32'd1,          32'd31,         32'h8000_0000};
    vecs[5] = '{3'b101, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000};
    vecs[6] = '{3'b101, 32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF};
    vecs[7] = '{3'b100, 32'h1234_5678,  32'h0000_0020,  32'h1234_5678};
    vecs[8] = '{3'b111, 32'h0000_1234,  32'h0000_5678,  32'h0000_0000};
    vecs[9] = '{3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000};

    rst_i   = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk("reset:valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset:data_o",  data_o, 32'd0);
    chk("reset:zero_o",  {31'd0, zero_o}, 32'd1);
    chk("reset:ready_o", {31'd0, ready_o}, 32'd1);
    #20;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single-cycle ops issued back to back.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      sb_q.push_back(vecs[i].exp);
      step_chk(1'b1, $sformatf("vec%0d", i));
    end
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    step_chk(1'b0, "pulse_end");
    chk("hold:data_o", data_o, 32'h8000_0000);

    // mul 7 * -3: the result appears exactly 33 cycles after issue.
    issue_mul(32'd7, 32'hFFFF_FFFD, 1'b1, "mul1");
    run_mul(1'b0, "mul1");
    chk("mul1:done_stall", {31'd0, stall_o}, 32'd0);
    chk("mul1:done_ready", {31'd0, ready_o}, 32'd1);
    step_chk(1'b0, "mul1_after");

    // mul 2^16 * 2^16 wraps to zero. An add presented while busy is ignored.
    // A new add is accepted in the cycle that presents the mul result.
    issue_mul(32'h0001_0000, 32'h0001_0000, 1'b1, "mul2");
    run_mul(1'b1, "mul2");
    drive(1'b1, 3'b000, 32'd1, 32'd2);
    sb_q.push_back(32'd3);
    #1;
    chk("b2b:stall", {31'd0, stall_o}, 32'd0);
    step_chk(1'b1, "b2b_add");
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    step_chk(1'b0, "b2b_after");

    // A flush on the 10th busy cycle aborts the mul without producing a result.
    issue_mul(32'd3, 32'd5, 1'b0, "flush10");
    for (int k = 1; k < 10; k++) step_chk(1'b0, "flush10_busy");
    flush_i = 1'b1;
    #1;
    chk("flush10:stall", {31'd0, stall_o}, 32'd0);
    step_chk(1'b0, "flush10_edge");
    flush_i = 1'b0;
    chk("flush10:ready", {31'd0, ready_o}, 32'd1);
    chk("flush10:data_o", data_o, 32'd3);
    for (int k = 0; k < 35; k++) step_chk(1'b0, "flush10_quiet");

    // A flush on the completion edge wins over the result.
    issue_mul(32'd2, 32'd3, 1'b0, "flushlast");
    for (int k = 1; k < 32; k++) step_chk(1'b0, "flushlast_busy");
    flush_i = 1'b1;
    step_chk(1'b0, "flushlast_edge");
    flush_i = 1'b0;
    chk("flushlast:data_o", data_o, 32'd3);
    chk("flushlast:ready", {31'd0, ready_o}, 32'd1);
    step_chk(1'b0, "flushlast_after");

    // A flush while idle blocks acceptance.
    drive(1'b1, 3'b000, 32'd4, 32'd4);
    flush_i = 1'b1;
    step_chk(1'b0, "flush_idle");
    flush_i = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    chk("flush_idle:data_o", data_o, 32'd3);

    // An asynchronous reset in the middle of a mul discards it.
    issue_mul(32'd9, 32'd9, 1'b0, "rstmul");
    for (int k = 0; k < 4; k++) step_chk(1'b0, "rstmul_busy");
    #2;
    rst_i = 1'b0;
    #1;
    chk("rstmul:valid_o", {31'd0, valid_o}, 32'd0);
    chk("rstmul:data_o",  data_o, 32'd0);
    chk("rstmul:ready_o", {31'd0, ready_o}, 32'd1);
    chk("rstmul:zero_o",  {31'd0, zero_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    for (int k = 0; k < 40; k++) step_chk(1'b0, "rstmul_quiet");
    chk("rstmul:data_after", data_o, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
